// File: rtl/move_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_parser: ASCII Connect-6 move stream to validated 0-based coords.    |
// | Optional: define MOVE_PARSER_DUPCHK_EN to reject identical stone pairs.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module move_parser #(
  parameter int BOARD_N = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rxdata_valid,
  output logic       colour,
  output logic       colour_valid,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       single,
  output logic [4:0] y1,
  output logic [4:0] x1,
  output logic [4:0] y2,
  output logic [4:0] x2,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    S_HDR = 4'd0,
    S_Y1T = 4'd1,
    S_Y1O = 4'd2,
    S_X1T = 4'd3,
    S_X1O = 4'd4,
    S_Y2T = 4'd5,
    S_Y2O = 4'd6,
    S_X2T = 4'd7,
    S_X2O = 4'd8,
    S_OUT = 4'd9
  } state_t;

  localparam logic [5:0] C_BOARD_N = 6'(BOARD_N);

  state_t     state_q, state_d;
  logic       colour_q, colour_d;
  logic       colour_valid_q, colour_valid_d;
  logic       first_q, first_d;
  logic       single_q, single_d;
  logic       tens_q, tens_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic [4:0] y1_q, y1_d, x1_q, x1_d, y2_q, y2_d, x2_q, x2_d;

  logic       is_crlf, is_hdr, is_digit, is_tens, in_range, dup;
  logic [4:0] coord_1b, coord;
  logic       raise;
  logic [1:0] raise_code;

  always_comb begin
    is_crlf  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_hdr   = (rx_data == 8'h42) || (rx_data == 8'h57);
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_tens  = (rx_data == 8'h30) || (rx_data == 8'h31);
    coord_1b = (tens_q ? 5'd10 : 5'd0) + {1'b0, rx_data[3:0]};
    in_range = (coord_1b != 5'd0) && ({1'b0, coord_1b} <= C_BOARD_N);
    coord    = coord_1b - 5'd1;
    dup      = 1'b0;
`ifdef MOVE_PARSER_DUPCHK_EN
    dup      = (y2_q == y1_q) && (coord == x1_q);
`else
    dup      = 1'b0;
`endif
  end

  always_comb begin
    state_d        = state_q;
    colour_d       = colour_q;
    colour_valid_d = 1'b0;
    first_d        = first_q;
    single_d       = single_q;
    tens_d         = tens_q;
    y1_d           = y1_q;
    x1_d           = x1_q;
    y2_d           = y2_q;
    x2_d           = x2_q;
    err_d          = 1'b0;
    err_code_d     = err_code_q;
    raise          = 1'b0;
    raise_code     = 2'd0;

    if (state_q == S_OUT && move_ready) begin
      state_d = S_Y1T;
      first_d = 1'b0;
    end

    if (rxdata_valid && !is_crlf) begin
      if (state_q == S_OUT) begin
        // Record stays pending; the byte is lost and reported as overrun.
        err_d      = 1'b1;
        err_code_d = 2'd2;
      end else if (is_hdr) begin
        colour_d       = (rx_data == 8'h57);
        first_d        = (rx_data == 8'h57);
        colour_valid_d = 1'b1;
        state_d        = S_Y1T;
      end else begin
        case (state_q)
          S_Y1T, S_X1T, S_Y2T, S_X2T: begin
            if (is_tens) begin
              tens_d = rx_data[0];
              case (state_q)
                S_Y1T:   state_d = S_Y1O;
                S_X1T:   state_d = S_X1O;
                S_Y2T:   state_d = S_Y2O;
                default: state_d = S_X2O;
              endcase
            end else begin
              raise = 1'b1;
            end
          end
          S_Y1O, S_X1O, S_Y2O, S_X2O: begin
            if (!is_digit) begin
              raise = 1'b1;
            end else if (!in_range) begin
              raise      = 1'b1;
              raise_code = 2'd1;
            end else begin
              case (state_q)
                S_Y1O: begin
                  y1_d    = coord;
                  state_d = S_X1T;
                end
                S_X1O: begin
                  x1_d = coord;
                  if (first_q) begin
                    single_d = 1'b1;
                    state_d  = S_OUT;
                  end else begin
                    state_d = S_Y2T;
                  end
                end
                S_Y2O: begin
                  y2_d    = coord;
                  state_d = S_X2T;
                end
                default: begin
                  x2_d = coord;
                  if (dup) begin
                    raise      = 1'b1;
                    raise_code = 2'd3;
                  end else begin
                    single_d = 1'b0;
                    state_d  = S_OUT;
                  end
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end

    if (raise) begin
      err_d      = 1'b1;
      err_code_d = raise_code;
      state_d    = S_Y1T;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_HDR;
      colour_q       <= 1'b0;
      colour_valid_q <= 1'b0;
      first_q        <= 1'b0;
      single_q       <= 1'b0;
      tens_q         <= 1'b0;
      y1_q           <= 5'd0;
      x1_q           <= 5'd0;
      y2_q           <= 5'd0;
      x2_q           <= 5'd0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      colour_q       <= colour_d;
      colour_valid_q <= colour_valid_d;
      first_q        <= first_d;
      single_q       <= single_d;
      tens_q         <= tens_d;
      y1_q           <= y1_d;
      x1_q           <= x1_d;
      y2_q           <= y2_d;
      x2_q           <= x2_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

  assign colour       = colour_q;
  assign colour_valid = colour_valid_q;
  assign move_valid   = (state_q == S_OUT);
  assign single       = single_q;
  assign y1           = y1_q;
  assign x1           = x1_q;
  assign y2           = y2_q;
  assign x2           = x2_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_move_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_move_parser: directed and random byte streams against a digit-list    |
// | reference model of the move stream grammar.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_move_parser;

  localparam int BOARD_N = 19;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rxdata_valid = 1'b0;
  logic       move_ready = 1'b0;
  logic       colour, colour_valid, move_valid, single, err;
  logic [4:0] y1, x1, y2, x2;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a list of received digits plus a pending record.
  int   digs[$];
  bit   m_hdr_wait, m_colour, m_first, m_pend, m_single, m_err, m_cv;
  int   m_code, m_y1, m_x1, m_y2, m_x2;

  move_parser #(.BOARD_N(BOARD_N)) dut (
    .clk(clk), .reset(reset_n), .rx_data(rx_data), .rxdata_valid(rxdata_valid),
    .colour(colour), .colour_valid(colour_valid), .move_valid(move_valid),
    .move_ready(move_ready), .single(single), .y1(y1), .x1(x1), .y2(y2), .x2(x2),
    .err(err), .err_code(err_code)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    digs.delete();
    m_hdr_wait = 1; m_colour = 0; m_first = 0; m_pend = 0; m_single = 0;
    m_err = 0; m_cv = 0; m_code = 0;
  endtask

  task automatic raise(input int c);
    m_err = 1; m_code = c; digs.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    bit was_pend;
    int val, need;
    m_err = 0; m_cv = 0;
    was_pend = m_pend;
    if (was_pend && move_ready) begin m_pend = 0; m_first = 0; end
    if (v && b != 8'h0D && b != 8'h0A) begin
      if (was_pend) raise(2);
      else if (b == 8'h42 || b == 8'h57) begin
        m_colour = (b == 8'h57); m_first = m_colour; m_cv = 1;
        m_hdr_wait = 0; digs.delete();
      end else if (m_hdr_wait) begin
      end else if (b >= 8'h30 && b <= 8'h39) begin
        val = int'(b) - 48;
        if (digs.size() % 2 == 0 && val > 1) raise(0);
        else begin
          digs.push_back(val);
          if (digs.size() % 2 == 0) begin
            val = digs[digs.size()-2] * 10 + digs[digs.size()-1];
            need = m_first ? 4 : 8;
            if (val < 1 || val > BOARD_N) raise(1);
            else if (digs.size() == need) begin
              m_y1 = digs[0]*10 + digs[1] - 1;
              m_x1 = digs[2]*10 + digs[3] - 1;
              if (need == 8) begin
                m_y2 = digs[4]*10 + digs[5] - 1;
                m_x2 = digs[6]*10 + digs[7] - 1;
              end
`ifdef MOVE_PARSER_DUPCHK_EN
              if (need == 8 && m_y1 == m_y2 && m_x1 == m_x2) raise(3);
              else begin m_pend = 1; m_single = m_first; digs.delete(); end
`else
              m_pend = 1; m_single = m_first; digs.delete();
`endif
            end
          end
        end
      end else raise(0);
    end
  endtask

  task automatic check_all();
    chk("move_valid", move_valid, m_pend);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("colour_valid", colour_valid, m_cv);
    chk("colour", colour, m_colour);
    if (m_pend) begin
      chk("single", single, m_single);
      chk("y1", y1, m_y1);
      chk("x1", x1, m_x1);
      if (!m_single) begin
        chk("y2", y2, m_y2);
        chk("x2", x2, m_x2);
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge clk);
    rxdata_valid = v; rx_data = b;
    model_step(v, b);
    @(posedge clk); #1;
    rxdata_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  // Bytes with a 2-cycle gap between them; the last one is not followed by a gap.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i]);
      if (i != s.len() - 1) idle(2);
    end
  endtask

  function automatic logic [7:0] gen_byte();
    logic [7:0] junk [6];
    int r;
    junk = '{8'h0D, 8'h0A, 8'h32, 8'h39, 8'h78, 8'h51};
    r = $urandom_range(0, 19);
    if (m_hdr_wait || r == 0) return ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h42;
    if (r == 1) return junk[$urandom_range(0, 5)];
    if (r == 2) return 8'(8'h30 + $urandom_range(0, 9));
    if (digs.size() % 2 == 0) return 8'(8'h30 + $urandom_range(0, 1));
    if (digs[digs.size()-1] != 0) return 8'(8'h30 + $urandom_range(0, 9));
    return 8'(8'h31 + $urandom_range(0, 8));
  endfunction

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_single", single, 0);
    chk("rst_y1", y1, 0);
    chk("rst_x2", x2, 0);
    @(negedge clk); reset_n = 1'b1;

    // Black header and one 8-digit record accepted immediately
    move_ready = 1'b1;
    send_str("B01191005");
    chk("t1_valid", move_valid, 1);
    chk("t1_y1", y1, 0);
    chk("t1_x1", x1, 18);
    chk("t1_y2", y2, 9);
    chk("t1_x2", x2, 4);
    chk("t1_single", single, 0);
    idle(1);
    chk("t1_one_cycle", move_valid, 0);

    // White header: single-stone opening record, then a full record
    move_ready = 1'b0;
    idle(2);
    send_str("W1010");
    chk("t2_single", single, 1);
    chk("t2_y1", y1, 9);
    chk("t2_x1", x1, 9);
    move_ready = 1'b1; idle(1); move_ready = 1'b0;
    idle(2);
    send_str("01020304");
    chk("t2b_valid", move_valid, 1);
    chk("t2b_single", single, 0);
    move_ready = 1'b1; idle(1); move_ready = 1'b0;

    // Bad tens digit, then an out-of-range coordinate, each followed by a good record
    idle(2);
    send_str("2");
    chk("t3_err", err, 1);
    chk("t3_code", err_code, 0);
    idle(2);
    send_str("19190101");
    chk("t3_rec", move_valid, 1);
    move_ready = 1'b1; idle(1); move_ready = 1'b0;
    idle(2);
    send_str("00");
    chk("t3r_err", err, 1);
    chk("t3r_code", err_code, 1);
    idle(2);
    send_str("05060708");
    chk("t3r_rec", move_valid, 1);
    chk("t3r_y2", y2, 6);

    // Overrun while a record is pending, including a header byte
    idle(2);
    send_str("5");
    chk("t4_code", err_code, 2);
    chk("t4_hold", move_valid, 1);
    chk("t4_y1", y1, 4);
    idle(2);
    send_str("W");
    chk("t4_colour", colour, 1);
    chk("t4_code2", err_code, 2);
    move_ready = 1'b1; idle(1); move_ready = 1'b0;

    // Duplicate stone pair
    idle(2);
    send_str("B05050505");
`ifdef MOVE_PARSER_DUPCHK_EN
    chk("t5_code", err_code, 3);
    chk("t5_valid", move_valid, 0);
`else
    chk("t5_valid", move_valid, 1);
    chk("t5_x2", x2, 4);
`endif
    move_ready = 1'b1; idle(1); move_ready = 1'b0;

    // Reset mid-record
    idle(2);
    send_str("W011");
    @(negedge clk); reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_y1", y1, 0);
    chk("t6_single", single, 0);
    idle(2);
    @(negedge clk); reset_n = 1'b1;
    move_ready = 1'b1;
    send_str("B12131415");
    chk("t6_valid", move_valid, 1);
    chk("t6_y1b", y1, 11);
    chk("t6_x2b", x2, 14);
    idle(2);

    // Random stream with random consumer back-pressure, including back-to-back strobes
    for (int i = 0; i < 3000; i++) begin
      move_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) cycle(1'b1, gen_byte());
      else cycle(1'b0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
